mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: drives a req/ack memory port, stalls upstream while an access is pending.
// Optional wait timeout with a sticky error flag is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  WriteReg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  WriteReg_o,
  output logic        err_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, stateNext;
  logic        access;
  logic        timeout;
  logic        heldRegWrite, heldMemtoReg, heldRead, heldWe;
  logic [31:0] heldAddr, heldWdata;
  logic [4:0]  heldWriteReg;

  assign access = MemRead_i | MemWrite_i;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] waitCnt;
  logic       errQ;

  // An ack on the terminal-count cycle wins, so the access completes without error.
  assign timeout = (state == WAIT) && !mem_ack_i && (waitCnt == 8'hFF);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waitCnt <= 8'd0;
      errQ    <= 1'b0;
    end else begin
      if (state == IDLE)
        waitCnt <= 8'd0;
      else if (!mem_ack_i && !timeout)
        waitCnt <= waitCnt + 8'd1;
      if (timeout)
        errQ <= 1'b1;
    end
  end

  assign err_o = errQ;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    stateNext = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_o   = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack_i || timeout)
          stateNext = IDLE;
        else
          stall_o = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // Holding registers capture the request once, so it cannot be reissued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      heldRegWrite <= 1'b0;
      heldMemtoReg <= 1'b0;
      heldRead     <= 1'b0;
      heldWe       <= 1'b0;
      heldAddr     <= 32'd0;
      heldWdata    <= 32'd0;
      heldWriteReg <= 5'd0;
    end else if (state == IDLE && access) begin
      heldRegWrite <= RegWrite_i;
      heldMemtoReg <= MemtoReg_i;
      heldRead     <= MemRead_i & ~MemWrite_i;
      heldWe       <= MemWrite_i;
      heldAddr     <= ALUResult_i;
      heldWdata    <= WriteData_i;
      heldWriteReg <= WriteReg_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= 32'd0;
      ALUResult_o <= 32'd0;
      WriteReg_o  <= 5'd0;
    end else if (state == IDLE && !access) begin
      RegWrite_o  <= RegWrite_i;
      MemtoReg_o  <= MemtoReg_i;
      ReadData_o  <= 32'd0;
      ALUResult_o <= ALUResult_i;
      WriteReg_o  <= WriteReg_i;
    end else if (state == WAIT && mem_ack_i) begin
      RegWrite_o  <= heldRegWrite;
      MemtoReg_o  <= heldMemtoReg;
      ReadData_o  <= heldRead ? mem_rdata_i : 32'd0;
      ALUResult_o <= heldAddr;
      WriteReg_o  <= heldWriteReg;
    end else begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= 32'd0;
      ALUResult_o <= 32'd0;
      WriteReg_o  <= 5'd0;
    end
  end

  assign mem_req_o   = (state == WAIT);
  assign mem_we_o    = mem_req_o & heldWe;
  assign mem_addr_o  = mem_req_o ? heldAddr  : 32'd0;
  assign mem_wdata_o = mem_req_o ? heldWdata : 32'd0;

endmodule
